switch_ctrl: RTL and testbench
==============================

SWITCH_CTRL -- requirements
Module: switch_ctrl

Interface
REQ-001 Parameter SW_WIDTH, default 24: number of switch inputs, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000: clean clock cycles required before a new switch value is accepted, >=2.
REQ-003 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: asynchronous, active-low reset.
REQ-005 Port switch  input  SW_WIDTH: raw, asynchronous DIP-switch levels.
REQ-006 Port rd_req  input  1: read request from the CPU I/O bus, held high until rd_ack.
REQ-007 Port rd_sel  input  1: 0 = data register, 1 = status register; stable while rd_req is high.
REQ-008 Port rd_ack  output  1: single-cycle read acknowledge.
REQ-009 Port rd_data  output  32: read result, valid when rd_ack is high.
REQ-010 Port irq  output  1: level interrupt, high while a committed change is unread.

Function
REQ-011 switch SHALL pass through a two-flop synchronizer; the FSM SHALL see only the synchronized value sync.
REQ-012 FSM states SHALL be IDLE, SETTLE and COMMIT.
REQ-013 IDLE: if sync != stable, go to SETTLE, latch candidate = sync and clear cnt; otherwise stay in IDLE.
REQ-014 SETTLE: if sync != candidate, reload candidate = sync and clear cnt, staying in SETTLE.
REQ-015 SETTLE: if sync == stable, abandon the change and return to IDLE (glitch rejected, no commit).
REQ-016 SETTLE: if sync == candidate and cnt == DEBOUNCE_CYCLES-1, go to COMMIT; otherwise cnt increments.
REQ-017 COMMIT: stable <= candidate, pending <= 1, then go to IDLE; COMMIT lasts exactly one cycle.
REQ-018 cnt width SHALL be $clog2(DEBOUNCE_CYCLES); cnt SHALL never wrap.
REQ-019 A clean raw step SHALL appear in stable exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples it.
REQ-020 rd_req high at a rising edge with rd_ack low SHALL produce rd_ack = 1 for exactly the next cycle; rd_req SHALL be ignored while rd_ack is high.
REQ-021 rd_sel=0 SHALL return zero-extended stable; rd_sel=1 SHALL return {30'b0, busy, pending}, where busy = (state != IDLE).
REQ-022 rd_data SHALL hold its value until the next rd_ack.
REQ-023 An acknowledged rd_sel=0 read SHALL clear pending; if a COMMIT occurs in the same cycle, pending SHALL stay 1 (set wins).
REQ-024 irq SHALL equal pending, registered.

Reset
REQ-025 While rst_n is low: state = IDLE; cnt, candidate, stable, synchronizer flops, pending, rd_ack, rd_data and irq SHALL all be 0.
REQ-026 Reset mid-SETTLE or mid-read SHALL discard the in-flight change or read with no ack; after release, a nonzero switch SHALL go through the full debounce.

Configuration
REQ-027 Macro SWITCH_IRQ_EN, when defined, SHALL enable pending, irq and the status pending bit as specified above.
REQ-028 Without SWITCH_IRQ_EN, irq SHALL be a constant 0, status bit 0 SHALL read 0, no pending flop SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-029 Package switch_pkg SHALL hold the FSM state enum, the rd_sel encodings and the status bit indices.
REQ-030 The synchronizer SHALL be a separate sub-module, switch_sync, parameterized by width; all remaining logic SHALL sit in switch_ctrl.

Verification (DEBOUNCE_CYCLES=4, SW_WIDTH=24)
REQ-031 Reset release with switch=24'h000000 -> stable=0, irq=0; reading rd_sel=0 returns 32'h0 with rd_ack one cycle after the request.
REQ-032 switch steps to 24'hA5A5A5 and holds -> stable=24'hA5A5A5 exactly 8 edges later, irq rises the next cycle, and rd_sel=0 returns 32'h00A5A5A5 and clears irq.
REQ-033 switch pulses to 24'h000001 for 2 cycles, then returns to 0 -> no commit, irq stays 0, busy seen high then low.
REQ-034 switch bounces 1->0->1 inside SETTLE, then holds 24'h000001 -> commit occurs 4 clean cycles after the last bounce, not before.
REQ-035 A rd_sel=0 ack coincides with a COMMIT of 24'h000003 -> rd_data returns the old value and pending/irq remain 1.
REQ-036 rst_n pulled low during SETTLE with switch=24'h0000FF -> all outputs 0; after release, commit occurs 8 edges later.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared types and encodings for the DIP-switch debounce controller.
// Consumed by switch_ctrl; the optional interrupt path is enabled with SWITCH_IRQ_EN.
package switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic RD_SEL_DATA   = 1'b0;
    localparam logic RD_SEL_STATUS = 1'b1;

    localparam int STAT_PENDING_BIT = 0;
    localparam int STAT_BUSY_BIT    = 1;

    function automatic logic [31:0] status_word(input logic busy, input logic pending);
        logic [31:0] w;
        w                   = '0;
        w[STAT_BUSY_BIT]    = busy;
        w[STAT_PENDING_BIT] = pending;
        return w;
    endfunction

endpackage

// File: rtl/switch_sync.sv
// Two-flop synchronizer for the raw, asynchronous switch levels.
module switch_sync #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/switch_ctrl.sv
// Debounced DIP-switch register with a CPU read port (data / status) and
// an optional level interrupt on committed changes, enabled by SWITCH_IRQ_EN.
module switch_ctrl
    import switch_pkg::*;
#(
    parameter int SW_WIDTH        = 24,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW_WIDTH-1:0] switch,
    input  logic                rd_req,
    input  logic                rd_sel,
    output logic                rd_ack,
    output logic [31:0]         rd_data,
    output logic                irq
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sync;
    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SW_WIDTH-1:0] cand_q, cand_d;
    logic [SW_WIDTH-1:0] stable_q, stable_d;
    logic                rd_ack_q, rd_ack_d;
    logic [31:0]         rd_data_q, rd_data_d;
    logic                busy;
    logic                commit;
    logic                rd_accept;
    logic                pending;

    switch_sync #(.WIDTH(SW_WIDTH)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (switch),
        .q     (sync)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Returning to the old stable value wins over everything: the change was a glitch.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sync != stable_q) begin
                    state_d = ST_SETTLE;
                    cand_d  = sync;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (sync == stable_q) begin
                    state_d = ST_IDLE;
                end else if (sync != cand_q) begin
                    cand_d = sync;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        busy   = (state_q != ST_IDLE);
        commit = (state_q == ST_COMMIT);
    end

    always_comb begin
        stable_d  = commit ? cand_q : stable_q;
        rd_accept = rd_req && !rd_ack_q;
        rd_ack_d  = rd_accept;
        rd_data_d = rd_data_q;
        if (rd_accept) begin
            if (rd_sel == RD_SEL_DATA) begin
                rd_data_d                 = '0;
                rd_data_d[SW_WIDTH-1:0]   = stable_q;
            end else begin
                rd_data_d = status_word(busy, pending);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            cand_q    <= '0;
            stable_q  <= '0;
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef SWITCH_IRQ_EN
    logic pending_q, pending_d;
    logic irq_q, irq_d;

    // A commit in the same cycle as a clearing data read keeps pending set.
    always_comb begin
        pending_d = commit || (pending_q && !(rd_accept && rd_sel == RD_SEL_DATA));
        irq_d     = pending_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign pending = pending_q;
    assign irq     = irq_q;
`else
    assign pending = 1'b0;
    assign irq     = 1'b0;
`endif

    assign rd_ack  = rd_ack_q;
    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_switch_ctrl.sv
// Directed testbench for switch_ctrl with DEBOUNCE_CYCLES=4, SW_WIDTH=24.
module tb_switch_ctrl;

`ifdef SWITCH_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [23:0] switch;
    logic        rd_req;
    logic        rd_sel;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        irq;

    int n_cmp;
    int n_err;

    switch_ctrl #(.SW_WIDTH(24), .DEBOUNCE_CYCLES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .switch  (switch),
        .rd_req  (rd_req),
        .rd_sel  (rd_sel),
        .rd_ack  (rd_ack),
        .rd_data (rd_data),
        .irq     (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // driver: one read transaction; lat = edges until ack (99 = none)
    task automatic do_read(input logic sel, output logic [31:0] data, output int lat,
                           output logic held);
        rd_sel = sel;
        rd_req = 1'b1;
        lat    = 99;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (rd_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        data   = rd_data;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        held = (rd_ack === 1'b0) && (rd_data === data);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int          lat;
        logic        held;
        rst_n  = 1'b0;
        switch = 24'h000000;
        rd_req = 1'b0;
        rd_sel = 1'b0;
        tick(3);
        n_cmp++;
        if ({rd_ack, rd_data, irq} !== 34'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got ack=%b data=%h irq=%b required all 0", rd_ack, rd_data, irq);
        end
        rst_n = 1'b1;
        tick(2);
        do_read(1'b0, d, lat, held);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data_read: got %h required %h", d, 32'h0);
        end
        n_cmp++;
        if (lat !== 1) begin
            n_err++;
            $display("FAIL reset_ack_latency: got %0d required 1", lat);
        end
        n_cmp++;
        if (held !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ack_single_hold: got %b required 1", held);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq: got %b required 0", irq);
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        int          lat;
        logic        held;
        switch = 24'h000001;
        tick(2);
        switch = 24'h000000;
        tick(1);
        // accepted at edge 4, while SETTLE is still active
        do_read(1'b1, d, lat, held);
        n_cmp++;
        if (d !== 32'h0000_0002) begin
            n_err++;
            $display("FAIL glitch_busy_high: got %h required %h", d, 32'h0000_0002);
        end
        tick(8);
        do_read(1'b1, d, lat, held);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL glitch_busy_low: got %h required %h", d, 32'h0);
        end
        n_cmp++;
        if (dut.stable_q !== 24'h000000) begin
            n_err++;
            $display("FAIL glitch_no_commit: got %h required %h", dut.stable_q, 24'h000000);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_irq: got %b required 0", irq);
        end
    endtask

    task automatic test_step();
        logic [31:0] d;
        logic [31:0] exp_stat;
        int          lat;
        logic        held;
        switch = 24'hA5A5A5;
        tick(7);
        n_cmp++;
        if (dut.stable_q !== 24'h000000) begin
            n_err++;
            $display("FAIL step_early: got %h required %h", dut.stable_q, 24'h000000);
        end
        tick(1);
        n_cmp++;
        if (dut.stable_q !== 24'hA5A5A5) begin
            n_err++;
            $display("FAIL step_edge8: got %h required %h", dut.stable_q, 24'hA5A5A5);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL step_irq_edge8: got %b required 0", irq);
        end
        tick(1);
        n_cmp++;
        if (irq !== IRQ_EN) begin
            n_err++;
            $display("FAIL step_irq_edge9: got %b required %b", irq, IRQ_EN);
        end
        exp_stat    = 32'h0;
        exp_stat[0] = IRQ_EN;
        do_read(1'b1, d, lat, held);
        n_cmp++;
        if (d !== exp_stat) begin
            n_err++;
            $display("FAIL step_status: got %h required %h", d, exp_stat);
        end
        do_read(1'b0, d, lat, held);
        n_cmp++;
        if (d !== 32'h00A5A5A5) begin
            n_err++;
            $display("FAIL step_data: got %h required %h", d, 32'h00A5A5A5);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL step_irq_cleared: got %b required 0", irq);
        end
        do_read(1'b1, d, lat, held);
        n_cmp++;
        if (d !== 32'h0) begin
            n_err++;
            $display("FAIL step_status_cleared: got %h required %h", d, 32'h0);
        end
    endtask

    task automatic test_bounce();
        logic [31:0] d;
        int          lat;
        logic        held;
        switch = 24'h000001;
        tick(3);
        switch = 24'h000000;
        tick(1);
        switch = 24'h000001;
        tick(4);
        n_cmp++;
        if (dut.stable_q !== 24'hA5A5A5) begin
            n_err++;
            $display("FAIL bounce_edge8: got %h required %h", dut.stable_q, 24'hA5A5A5);
        end
        tick(3);
        n_cmp++;
        if (dut.stable_q !== 24'hA5A5A5) begin
            n_err++;
            $display("FAIL bounce_edge11: got %h required %h", dut.stable_q, 24'hA5A5A5);
        end
        tick(1);
        n_cmp++;
        if (dut.stable_q !== 24'h000001) begin
            n_err++;
            $display("FAIL bounce_edge12: got %h required %h", dut.stable_q, 24'h000001);
        end
        tick(1);
        n_cmp++;
        if (irq !== IRQ_EN) begin
            n_err++;
            $display("FAIL bounce_irq: got %b required %b", irq, IRQ_EN);
        end
        do_read(1'b0, d, lat, held);
        n_cmp++;
        if (d !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL bounce_data: got %h required %h", d, 32'h0000_0001);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] exp_stat;
        int          lat;
        logic        held;
        switch = 24'h000003;
        tick(7);
        // data read accepted on edge 8, the same edge COMMIT updates stable
        do_read(1'b0, d, lat, held);
        n_cmp++;
        if (d !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL collide_old_data: got %h required %h", d, 32'h0000_0001);
        end
        n_cmp++;
        if (irq !== IRQ_EN) begin
            n_err++;
            $display("FAIL collide_irq_kept: got %b required %b", irq, IRQ_EN);
        end
        exp_stat    = 32'h0;
        exp_stat[0] = IRQ_EN;
        do_read(1'b1, d, lat, held);
        n_cmp++;
        if (d !== exp_stat) begin
            n_err++;
            $display("FAIL collide_status: got %h required %h", d, exp_stat);
        end
        do_read(1'b0, d, lat, held);
        n_cmp++;
        if (d !== 32'h0000_0003) begin
            n_err++;
            $display("FAIL collide_new_data: got %h required %h", d, 32'h0000_0003);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL collide_irq_cleared: got %b required 0", irq);
        end
    endtask

    task automatic test_reset_mid_settle();
        logic [31:0] d;
        int          lat;
        logic        held;
        switch = 24'h0000FF;
        tick(4);
        rd_sel = 1'b0;
        rd_req = 1'b1;
        rst_n  = 1'b0;
        #1;
        n_cmp++;
        if ({rd_ack, rd_data, irq} !== 34'h0 || dut.stable_q !== 24'h0) begin
            n_err++;
            $display("FAIL midreset_outputs: got ack=%b data=%h irq=%b stable=%h required all 0",
                     rd_ack, rd_data, irq, dut.stable_q);
        end
        tick(2);
        n_cmp++;
        if (rd_ack !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_ack: got %b required 0", rd_ack);
        end
        rd_req = 1'b0;
        rst_n  = 1'b1;
        tick(1);
        n_cmp++;
        if (rd_ack !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_no_stray_ack: got %b required 0", rd_ack);
        end
        tick(6);
        n_cmp++;
        if (dut.stable_q !== 24'h000000) begin
            n_err++;
            $display("FAIL midreset_edge7: got %h required %h", dut.stable_q, 24'h000000);
        end
        tick(1);
        n_cmp++;
        if (dut.stable_q !== 24'h0000FF) begin
            n_err++;
            $display("FAIL midreset_edge8: got %h required %h", dut.stable_q, 24'h0000FF);
        end
        tick(1);
        do_read(1'b0, d, lat, held);
        n_cmp++;
        if (d !== 32'h0000_00FF) begin
            n_err++;
            $display("FAIL midreset_data: got %h required %h", d, 32'h0000_00FF);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        switch = '0;
        rd_req = 1'b0;
        rd_sel = 1'b0;
        test_reset();
        test_glitch();
        test_step();
        test_bounce();
        test_back_to_back();
        test_reset_mid_settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
